// File: rtl/fifo_lvl_pkg.sv
// Shared constants for the level-tracking FIFO: default geometry and level-width rule.
package fifo_lvl_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_LOG_NUM_SLOTS = 4;

  // Occupancy runs 0..NUM_SLOTS inclusive, so it needs one bit more than a pointer.
  function automatic int level_width(input int log_num_slots);
    return log_num_slots + 1;
  endfunction

endpackage

// File: rtl/fifo_lvl_if.sv
// Handshake, status and threshold bundle between a FIFO user (master) and fifo_lvl (slave).
interface fifo_lvl_if import fifo_lvl_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LOG_NUM_SLOTS = DEF_LOG_NUM_SLOTS
);
  localparam int LVL_W = level_width(LOG_NUM_SLOTS);

  logic [DATA_WIDTH-1:0] data_write;
  logic                  write;
  logic                  full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] data_read;
  logic                  next_read;
  logic                  empty;
  logic                  almost_empty;
  logic [LVL_W-1:0]      level;
  logic [LVL_W-1:0]      af_level;
  logic [LVL_W-1:0]      ae_level;
  logic                  overflow;
  logic                  underflow;
  logic                  clear_err;

  modport master (
    output data_write, write, next_read, af_level, ae_level, clear_err,
    input  full, almost_full, data_read, empty, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  data_write, write, next_read, af_level, ae_level, clear_err,
    output full, almost_full, data_read, empty, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_lvl_ram.sv
// Simple dual-port storage for fifo_lvl: synchronous write port, asynchronous read port.
module fifo_lvl_ram import fifo_lvl_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LOG_NUM_SLOTS = DEF_LOG_NUM_SLOTS
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [LOG_NUM_SLOTS-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [LOG_NUM_SLOTS-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  localparam int NUM_SLOTS = 2 ** LOG_NUM_SLOTS;

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// First-word-fall-through FIFO with occupancy level, run-time thresholds and optional
// sticky overflow/underflow flags (enabled by defining FIFO_LVL_ERR_FLAGS_EN).
module fifo_lvl import fifo_lvl_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LOG_NUM_SLOTS = DEF_LOG_NUM_SLOTS
) (
  input logic       clk,
  input logic       rst,
  fifo_lvl_if.slave bus
);
  localparam int NUM_SLOTS = 2 ** LOG_NUM_SLOTS;
  localparam int LVL_W     = level_width(LOG_NUM_SLOTS);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(NUM_SLOTS);

  logic [LOG_NUM_SLOTS-1:0] wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr;
  logic [LVL_W-1:0]         level;
  logic                     full;
  logic                     empty;
  logic                     wr_ok;
  logic                     rd_ok;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  // Status flags come from the registered level only, never from the request inputs.
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  // A pop frees the slot in the same edge, so a full FIFO may still take a write.
  assign wr_ok = bus.write && (!full || bus.next_read);
  assign rd_ok = bus.next_read && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + LOG_NUM_SLOTS'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + LOG_NUM_SLOTS'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  fifo_lvl_ram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LOG_NUM_SLOTS (LOG_NUM_SLOTS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_write),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign bus.data_read    = empty ? '0 : ram_rdata;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.level        = level;
  assign bus.almost_full  = (level >= bus.af_level);
  assign bus.almost_empty = (level <= bus.ae_level);

`ifdef FIFO_LVL_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  // A new error in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.write && full && !bus.next_read) begin
        overflow <= 1'b1;
      end else if (bus.clear_err) begin
        overflow <= 1'b0;
      end
      if (bus.next_read && empty) begin
        underflow <= 1'b1;
      end else if (bus.clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`else
  logic unused_clear_err;

  assign unused_clear_err = bus.clear_err;
  assign bus.overflow     = 1'b0;
  assign bus.underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// Self-checking bench for fifo_lvl (depth 4) with a queue scoreboard and a level/flag model.
module tb_fifo_lvl;
  localparam int DW    = 8;
  localparam int LOGN  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_lvl_if #(.DATA_WIDTH(DW), .LOG_NUM_SLOTS(LOGN)) bus ();

  fifo_lvl #(.DATA_WIDTH(DW), .LOG_NUM_SLOTS(LOGN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mlvl  = 0;
  bit m_ov  = 1'b0;
  bit m_un  = 1'b0;
  logic [DW-1:0] sb[$];

  // One clock of stimulus; the model tracks what the FIFO should hold afterwards.
  task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
    bit wr_ok;
    bit rd_ok;
    rst            = rs;
    bus.write      = w;
    bus.data_write = d;
    bus.next_read  = r;
    bus.clear_err  = c;
    wr_ok = w && (mlvl < DEPTH || r);
    rd_ok = r && (mlvl > 0);
    if (rs) begin
      sb.delete();
      mlvl = 0;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
`ifdef FIFO_LVL_ERR_FLAGS_EN
      if (w && mlvl == DEPTH && !r) m_ov = 1'b1;
      else if (c) m_ov = 1'b0;
      if (r && mlvl == 0) m_un = 1'b1;
      else if (c) m_un = 1'b0;
`endif
      if (rd_ok) void'(sb.pop_front());
      if (wr_ok) sb.push_back(d);
      mlvl = mlvl + int'(wr_ok) - int'(rd_ok);
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.write     = 1'b0;
    bus.next_read = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  task automatic test_reset();
    bus.af_level = 3'd0;
    bus.ae_level = 3'd1;
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
    total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    total++; if (bus.data_read !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.data_read); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_unf got=%b want=0", bus.underflow); end
    total++; if (bus.almost_full !== 1'b1) begin bad++; $display("FAIL reset_af0 got=%b want=1", bus.almost_full); end
    total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b want=1", bus.almost_empty); end
    bus.af_level = 3'd3;
    #1;
    total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af3 got=%b want=0", bus.almost_full); end
  endtask

  task automatic test_fill();
    // Thresholds af=3, ae=1: levels 0..4 give ae 1,1,0,0,0 and af 0,0,0,1,1.
    logic [4:0] exp_ae = 5'b00011;
    logic [4:0] exp_af = 5'b11000;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i > 0) drive(1'b1, 8'(17 * i), 1'b0, 1'b0, 1'b0);
      total++; if (bus.level !== 3'(i)) begin bad++; $display("FAIL fill_level got=%0d want=%0d", bus.level, i); end
      total++; if (bus.almost_empty !== exp_ae[i]) begin bad++; $display("FAIL fill_ae lvl=%0d got=%b want=%b", i, bus.almost_empty, exp_ae[i]); end
      total++; if (bus.almost_full !== exp_af[i]) begin bad++; $display("FAIL fill_af lvl=%0d got=%b want=%b", i, bus.almost_full, exp_af[i]); end
      total++; if (bus.full !== (i == DEPTH)) begin bad++; $display("FAIL fill_full lvl=%0d got=%b", i, bus.full); end
    end
    total++; if (bus.data_read !== 8'h11) begin bad++; $display("FAIL fill_head got=%h want=11", bus.data_read); end
  endtask

  task automatic test_full_rw();
    total++; if (bus.data_read !== sb[0]) begin bad++; $display("FAIL frw_head got=%h want=%h", bus.data_read, sb[0]); end
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    total++; if (bus.level !== 3'd4) begin bad++; $display("FAIL frw_level got=%0d want=4", bus.level); end
    total++; if (bus.data_read !== 8'h22) begin bad++; $display("FAIL frw_next got=%h want=22", bus.data_read); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL frw_ovf got=%b want=0", bus.overflow); end
  endtask

  task automatic test_overflow();
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    total++; if (bus.level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d want=4", bus.level); end
    total++; if (bus.overflow !== m_ov) begin bad++; $display("FAIL ovf_set got=%b want=%b", bus.overflow, m_ov); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (bus.overflow !== m_ov) begin bad++; $display("FAIL ovf_sticky got=%b want=%b", bus.overflow, m_ov); end
    drive(1'b1, 8'h78, 1'b0, 1'b1, 1'b0);
    total++; if (bus.overflow !== m_ov) begin bad++; $display("FAIL ovf_setwins got=%b want=%b", bus.overflow, m_ov); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", bus.overflow); end
    // Drain: contents must be 22,33,44,55 untouched by the rejected writes.
    while (mlvl > 0) begin
      total++; if (bus.data_read !== sb[0]) begin bad++; $display("FAIL drain_data got=%h want=%h", bus.data_read, sb[0]); end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (bus.level !== 3'(mlvl)) begin bad++; $display("FAIL drain_level got=%0d want=%0d", bus.level, mlvl); end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", bus.empty); end
    total++; if (bus.data_read !== 8'h00) begin bad++; $display("FAIL drain_zero got=%h want=00", bus.data_read); end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    total++; if (bus.level !== 3'd1) begin bad++; $display("FAIL erw_level got=%0d want=1", bus.level); end
    total++; if (bus.data_read !== 8'hA5) begin bad++; $display("FAIL erw_data got=%h want=a5", bus.data_read); end
    total++; if (bus.underflow !== m_un) begin bad++; $display("FAIL erw_unf got=%b want=%b", bus.underflow, m_un); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL erw_clear got=%b want=0", bus.underflow); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL erw_pop got=%b want=1", bus.empty); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 400; n++) begin
      total++;
      if (mlvl > 0) begin
        if (bus.data_read !== sb[0]) begin bad++; $display("FAIL b2b_data n=%0d got=%h want=%h", n, bus.data_read, sb[0]); end
      end else begin
        if (bus.data_read !== 8'h00) begin bad++; $display("FAIL b2b_zero n=%0d got=%h want=00", n, bus.data_read); end
      end
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b0);
      total++; if (bus.level !== 3'(mlvl)) begin bad++; $display("FAIL b2b_level n=%0d got=%0d want=%0d", n, bus.level, mlvl); end
      total++; if ({bus.overflow, bus.underflow} !== {m_ov, m_un}) begin bad++; $display("FAIL b2b_err n=%0d got=%b%b want=%b%b", n, bus.overflow, bus.underflow, m_ov, m_un); end
    end
  endtask

  task automatic test_reset_mid();
    while (mlvl < 3) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    while (mlvl > 3) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (bus.level !== 3'd3) begin bad++; $display("FAIL rmid_pre got=%0d want=3", bus.level); end
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL rmid_level got=%0d want=0", bus.level); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%b want=1", bus.empty); end
    total++; if (bus.data_read !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want=00", bus.data_read); end
    drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    total++; if (bus.data_read !== 8'h12) begin bad++; $display("FAIL rmid_head got=%h want=12", bus.data_read); end
    total++; if (bus.level !== 3'd1) begin bad++; $display("FAIL rmid_level1 got=%0d want=1", bus.level); end
  endtask

  initial begin
    bus.write      = 1'b0;
    bus.next_read  = 1'b0;
    bus.clear_err  = 1'b0;
    bus.data_write = '0;
    bus.af_level   = 3'd3;
    bus.ae_level   = 3'd1;
    test_reset();
    test_fill();
    test_full_rw();
    test_overflow();
    test_empty_rw();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_lvl.md
FIFO_LVL -- requirements
Module: fifo_lvl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, entry width in bits.
REQ-002 SHALL have parameter LOG_NUM_SLOTS, default 4, log2 of depth; depth NUM_SLOTS = 2**LOG_NUM_SLOTS is a derived localparam, legal range 1..12.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_write  input  DATA_WIDTH  write data.
REQ-006 SHALL have port write  input  1  write request.
REQ-007 SHALL have port full  output  1  level == NUM_SLOTS.
REQ-008 SHALL have port almost_full  output  1  level >= af_level.
REQ-009 SHALL have port data_read  output  DATA_WIDTH  head entry, combinational.
REQ-010 SHALL have port next_read  input  1  pop head.
REQ-011 SHALL have port empty  output  1  level == 0.
REQ-012 SHALL have port almost_empty  output  1  level <= ae_level.
REQ-013 SHALL have port level  output  LOG_NUM_SLOTS+1  current occupancy.
REQ-014 SHALL have ports af_level, ae_level  input  LOG_NUM_SLOTS+1  run-time thresholds, quasi-static.
REQ-015 SHALL have ports overflow, underflow  output  1  sticky error flags; clear_err  input  1  clears them.

Function
REQ-016 Write SHALL be accepted when write & (~full | next_read); accepted data stored at write pointer, pointer +1 mod NUM_SLOTS.
REQ-017 Pop SHALL be accepted when next_read & ~empty; read pointer +1 mod NUM_SLOTS.
REQ-018 level SHALL be +1 on accepted write only, -1 on accepted pop only, unchanged on both or neither; never exceeds NUM_SLOTS or wraps below 0.
REQ-019 Write when full with simultaneous next_read SHALL accept both; level stays NUM_SLOTS.
REQ-020 next_read when empty SHALL be ignored even with simultaneous write; written word appears next cycle.
REQ-021 data_read SHALL present the head entry when ~empty and all-zeros when empty; first-word fall-through, write-to-read latency one cycle.
REQ-022 Pointers SHALL wrap silently; ordering SHALL be strict FIFO across wrap.
REQ-023 full, empty, almost_full, almost_empty SHALL be decoded combinationally from the registered level only (no input-to-flag paths).
REQ-024 Thresholds af_level = 0 SHALL make almost_full constant 1; ae_level >= NUM_SLOTS SHALL make almost_empty constant 1.

Reset
REQ-025 rst high at a clock edge SHALL clear pointers and level, overriding any simultaneous write/next_read; stored data need not be cleared.
REQ-026 Outputs after reset SHALL be: empty 1, full 0, level 0, data_read 0, overflow 0, underflow 0, almost_full = (af_level == 0), almost_empty 1.
REQ-027 Reset asserted mid-stream SHALL discard all contents; first write afterwards SHALL be the next head.

Configuration
REQ-028 Macro FIFO_LVL_ERR_FLAGS_EN defined: overflow sets on write & full & ~next_read, underflow sets on next_read & empty; both sticky until clear_err; set wins over same-cycle clear_err.
REQ-029 Macro FIFO_LVL_ERR_FLAGS_EN undefined: overflow and underflow SHALL be constant 0, clear_err unused, no flag registers synthesised; all other behaviour identical.

Structure
REQ-030 Shared header/package SHALL hold default DATA_WIDTH and LOG_NUM_SLOTS constants and the level-width expression LOG_NUM_SLOTS+1.
REQ-031 Storage SHALL be sub-module fifo_lvl_ram: simple dual-port array, synchronous write, asynchronous read, parameters DATA_WIDTH and LOG_NUM_SLOTS.
REQ-032 Control (pointers, level, flags, error logic) SHALL reside in fifo_lvl.

Verification
REQ-033 Fill: LOG_NUM_SLOTS=2, write 0x11..0x44 on 4 cycles -> level 1,2,3,4; full=1 after 4th; data_read=0x11.
REQ-034 Full + write+next_read: on full FIFO write 0x55 with next_read -> level stays 4, data_read becomes 0x22, 0x55 later read 5th.
REQ-035 Empty + write+next_read: on empty FIFO write 0xA5 with next_read -> next cycle level 1, data_read 0xA5, underflow 1 (macro on) / 0 (macro off).
REQ-036 Thresholds: af_level 3, ae_level 1; levels 0..4 -> almost_empty 1,1,0,0,0; almost_full 0,0,0,1,1.
REQ-037 Overflow: full FIFO, write 0x77 without next_read -> level 4, contents unchanged, overflow 1 until clear_err pulse; clear_err with coincident overflow keeps 1.
REQ-038 Reset mid-operation: level 3, assert rst with write 0x99 -> next cycle level 0, empty 1, data_read 0; then write 0x12 -> data_read 0x12.
